asteroid_path: RTL

Per-asteroid trajectory generator for the asteroid game. It sits directly upstream of the top-level pixel compositor and supplies the sprite's screen position and visibility each frame. It spawns an asteroid after a random frame delay, moves it down with a seeded speed and sideways drift that bounces at the screen edges, and reports a landing. Motion freezes while the game is halted on a collision.

---
 rtl/game_pkg.sv | 20 ++
 rtl/frame_tick.sv | 18 +
 rtl/asteroid_path.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg
// Shared constants and types for the asteroid game blocks.
//   - screen geometry (640 x 480)
//   - asteroid sprite width (37)
//   - asteroid FSM state enum
//   - spawn multiplier that spreads a 5-bit seed across the screen width
package game_pkg;

   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;
   localparam int SPRITE_W   = 37;
   localparam int SPAWN_MULT = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      FALL  = 2'd2
   } ast_state_t;

endpackage

// File: rtl/frame_tick.sv
// frame_tick
// Produces a single-cycle strobe once per frame when the VGA scan reaches
// column 0 of row V_TICK. Shared by the asteroid, score and dinosprite blocks.
// Ports:
//   vaddress  in  10  current scan row
//   haddress  in  10  current scan column
//   tick      out 1   high for exactly one pixel clock per frame
module frame_tick #(
   parameter int V_TICK = 480
) (
   input  logic [9:0] vaddress,
   input  logic [9:0] haddress,
   output logic       tick
);

   assign tick = (vaddress == 10'(V_TICK)) && (haddress == 10'd0);

endmodule

// File: rtl/asteroid_path.sv
// asteroid_path
// Trajectory generator for one asteroid. After a random frame delay it spawns
// the asteroid at a seeded column, moves it down at a seeded speed with a
// sideways drift that bounces off the screen edges, and pulses landed when it
// reaches the bottom. All motion happens on the frame tick (vertical blank), so
// the compositor never sees a mid-frame move. halt freezes everything.
// Ports:
//   clk       in  1   pixel clock (divided_clk domain)
//   reset     in  1   synchronous, active-high
//   halt      in  1   collision freeze
//   enable    in  1   spawning allowed
//   vaddress  in  10  current scan row
//   haddress  in  10  current scan column
//   seed      in  5   random value, sampled at delay-load and spawn
//   xpos      out 10  sprite left edge
//   ypos      out 10  sprite top edge
//   visible   out 1   high while the asteroid is falling
//   landed    out 1   one-cycle pulse when the asteroid reaches the bottom
module asteroid_path
   import game_pkg::*;
#(
   parameter int X_MAX  = SCREEN_W - SPRITE_W,
   parameter int Y_END  = SCREEN_H,
   parameter int V_TICK = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       halt,
   input  logic       enable,
   input  logic [9:0] vaddress,
   input  logic [9:0] haddress,
   input  logic [4:0] seed,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic       visible,
   output logic       landed
);

   ast_state_t         state;
   ast_state_t         state_next;
   logic               tick;
   logic               step;
   logic [4:0]         delay;
   logic [2:0]         speed;
   logic [1:0]         dx_mag;
   logic               dir_right;
   logic [10:0]        ynext;
   logic signed [10:0] xnext;
   logic               land;
   logic [9:0]         spawn_x;
   logic [4:0]         load_delay;

   frame_tick #(.V_TICK(V_TICK)) u_frame_tick (
      .vaddress (vaddress),
      .haddress (haddress),
      .tick     (tick)
   );

   // A tick that arrives while halted is simply dropped.
   assign step = tick && !halt;

   // Widened arithmetic so the bottom and left-edge overflows are detectable.
   assign ynext      = {1'b0, ypos} + {8'b0, speed};
   assign land       = (ynext >= 11'(Y_END));
   assign xnext      = dir_right ? ($signed({1'b0, xpos}) + $signed({9'b0, dx_mag}))
                                 : ($signed({1'b0, xpos}) - $signed({9'b0, dx_mag}));
   assign spawn_x    = 10'({5'b0, seed} * 10'(SPAWN_MULT));
   assign load_delay = {1'b0, seed[3:0]} + 5'd1;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; transitions only on an un-halted tick.
   always_comb begin
      state_next = state;
      if (step) begin
         case (state)
            IDLE:    if (enable) state_next = DELAY;
            DELAY:   begin
                        if (!enable)           state_next = IDLE;
                        else if (delay == 5'd1) state_next = FALL;
                     end
            FALL:    if (land) state_next = enable ? DELAY : IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output logic; visibility follows the registered state directly.
   always_comb begin
      visible = (state == FALL);
   end

   // Datapath: delay counter, spawn parameters and position update.
   // On the landing tick the asteroid is retired, so neither axis moves.
   always_ff @(posedge clk) begin
      if (reset) begin
         xpos      <= 10'd0;
         ypos      <= 10'd0;
         landed    <= 1'b0;
         delay     <= 5'd0;
         speed     <= 3'd1;
         dx_mag    <= 2'd1;
         dir_right <= 1'b0;
      end else begin
         landed <= 1'b0;
         if (step) begin
            case (state)
               IDLE: begin
                  if (enable) delay <= load_delay;
               end
               DELAY: begin
                  if (!enable) begin
                     delay <= 5'd0;
                  end else begin
                     delay <= delay - 5'd1;
                     if (delay == 5'd1) begin
                        xpos      <= spawn_x;
                        ypos      <= 10'd0;
                        speed     <= {1'b0, seed[1:0]} + 3'd1;
                        dx_mag    <= seed[2] ? 2'd2 : 2'd1;
                        dir_right <= seed[4];
                     end
                  end
               end
               FALL: begin
                  if (land) begin
                     landed <= 1'b1;
                     delay  <= enable ? load_delay : 5'd0;
                  end else begin
                     ypos <= ynext[9:0];
                     if (xnext < 11'sd0) begin
                        xpos      <= 10'd0;
                        dir_right <= 1'b1;
                     end else if (xnext > $signed(11'(X_MAX))) begin
                        xpos      <= 10'(X_MAX);
                        dir_right <= 1'b0;
                     end else begin
                        xpos <= xnext[9:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
